rv_iopmp_check_arbiter: RTL and testbench



---
 rtl/rv_iopmp_pkg.sv | 40 ++++
 rtl/rv_iopmp_rr_arbiter.sv | 42 ++++
 rtl/rv_iopmp_check_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rv_iopmp_check_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP check path.
// Contents: access_t, the check-arbiter FSM state enum, the check request
// payload struct (sized for the widest supported configuration) and an
// index-width helper.
package rv_iopmp_pkg;

    localparam int unsigned ACCESS_W     = 2;
    localparam int unsigned MAX_ADDR_W   = 64;
    localparam int unsigned MAX_NBYTES_W = 16;
    localparam int unsigned MAX_SID_W    = 16;

    typedef enum logic [ACCESS_W-1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_RW    = 2'd3
    } access_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } chk_state_e;

    // Fields are zero-extended from the instance widths into these maxima.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0]   addr;
        logic [MAX_ADDR_W-1:0]   len;
        logic [MAX_NBYTES_W-1:0] nbytes;
        logic [MAX_SID_W-1:0]    sid;
        access_t                 access;
    } chk_req_t;

    // Width of a port index; at least one bit even for a single port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Round-robin grant selection (purely combinational).
// Ports:
//   req_i        per-port request bits
//   last_grant_i index of the most recently served port
//   grant_o      one-hot grant (zero when nothing requests)
//   grant_idx_o  index of the granted port
//   any_o        at least one request present
module rv_iopmp_rr_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [idx_width(NUM_PORTS)-1:0]   last_grant_i,
    output logic [NUM_PORTS-1:0]              grant_o,
    output logic [idx_width(NUM_PORTS)-1:0]   grant_idx_o,
    output logic                              any_o
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    logic [IDX_W-1:0] cand;

    // Search last_grant+1 .. last_grant+NUM_PORTS modulo NUM_PORTS; first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_grant_i) + i) % NUM_PORTS);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                grant_idx_o = cand;
            end
        end
        if (any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rv_iopmp_check_arbiter.sv
// Shares one IOPMP matching-logic instance between NUM_PORTS requesters.
// One check is outstanding at a time: IDLE grants a port round-robin,
// ISSUE presents the latched request, WAIT collects the verdict, RESP
// holds it on the granted port until consumed.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   req_valid_i / req_ready_o          per-port request handshake
//   req_addr_i, req_len_i, req_nbytes_i, req_sid_i, req_access_i
//                                      per-port payloads, flattened port-major
//   rsp_valid_o / rsp_allow_o / rsp_ready_i  per-port verdict handshake
//   chk_en_o, chk_addr_o, chk_len_o, chk_nbytes_o, chk_sid_o, chk_access_o
//                                      request to the matching logic
//   chk_ready_i, chk_valid_i, chk_allow_i    matching-logic handshake/verdict
//   timeout_o                          one-cycle pulse when a check times out
// Optional feature: define RV_IOPMP_CHECK_TIMEOUT_EN to bound WAIT to
// TIMEOUT_CYCLES cycles (verdict forced to deny); otherwise WAIT is unbounded
// and timeout_o is tied low.
module rv_iopmp_check_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned SID_WIDTH      = 2,
    parameter int unsigned NBYTES_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_valid_i,
    output logic [NUM_PORTS-1:0]              req_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_len_i,
    input  logic [NUM_PORTS*NBYTES_WIDTH-1:0] req_nbytes_i,
    input  logic [NUM_PORTS*SID_WIDTH-1:0]    req_sid_i,
    input  logic [NUM_PORTS*ACCESS_W-1:0]     req_access_i,
    output logic [NUM_PORTS-1:0]              rsp_valid_o,
    output logic [NUM_PORTS-1:0]              rsp_allow_o,
    input  logic [NUM_PORTS-1:0]              rsp_ready_i,
    output logic                              chk_en_o,
    output logic [ADDR_WIDTH-1:0]             chk_addr_o,
    output logic [ADDR_WIDTH-1:0]             chk_len_o,
    output logic [NBYTES_WIDTH-1:0]           chk_nbytes_o,
    output logic [SID_WIDTH-1:0]              chk_sid_o,
    output logic [ACCESS_W-1:0]               chk_access_o,
    input  logic                              chk_ready_i,
    input  logic                              chk_valid_i,
    input  logic                              chk_allow_i,
    output logic                              timeout_o
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    chk_state_e           state_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_PORTS-1:0] oh_q;
    chk_req_t             pl_q;

    logic [NUM_PORTS-1:0] gnt_oh;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_any;

    chk_req_t             req_pl [NUM_PORTS];

    // Unflatten per-port payloads into the shared struct.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign req_pl[p] = '{
            addr:   MAX_ADDR_W'(req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
            len:    MAX_ADDR_W'(req_len_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
            nbytes: MAX_NBYTES_W'(req_nbytes_i[p*NBYTES_WIDTH +: NBYTES_WIDTH]),
            sid:    MAX_SID_W'(req_sid_i[p*SID_WIDTH +: SID_WIDTH]),
            access: access_t'(req_access_i[p*ACCESS_W +: ACCESS_W])
        };
    end

    rv_iopmp_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (gnt_oh),
        .grant_idx_o  (gnt_idx),
        .any_o        (gnt_any)
    );

`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign timeout_o  = 1'b0;
`endif

    // Check FSM; every output is a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            idx_q        <= '0;
            oh_q         <= '0;
            pl_q         <= '0;
            req_ready_o  <= '0;
            rsp_valid_o  <= '0;
            rsp_allow_o  <= '0;
            chk_en_o     <= 1'b0;
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_o    <= 1'b0;
`endif
        end else begin
            req_ready_o <= '0;
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        req_ready_o <= gnt_oh;
                        idx_q       <= gnt_idx;
                        oh_q        <= gnt_oh;
                        pl_q        <= req_pl[gnt_idx];
                        chk_en_o    <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (chk_ready_i) begin
                        chk_en_o <= 1'b0;
                        state_q  <= ST_WAIT;
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (chk_valid_i) begin
                        rsp_valid_o <= oh_q;
                        rsp_allow_o <= chk_allow_i ? oh_q : '0;
                        state_q     <= ST_RESP;
                    end
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
                    // Last allowed WAIT cycle without a verdict: deny and flag.
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_o <= oh_q;
                        rsp_allow_o <= '0;
                        timeout_o   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if ((rsp_ready_i & oh_q) != '0) begin
                        rsp_valid_o  <= '0;
                        rsp_allow_o  <= '0;
                        last_grant_q <= idx_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign chk_addr_o   = pl_q.addr[ADDR_WIDTH-1:0];
    assign chk_len_o    = pl_q.len[ADDR_WIDTH-1:0];
    assign chk_nbytes_o = pl_q.nbytes[NBYTES_WIDTH-1:0];
    assign chk_sid_o    = pl_q.sid[SID_WIDTH-1:0];
    assign chk_access_o = pl_q.access;

    // Pad bits above the configured widths are always zero.
    logic unused_pl;
    assign unused_pl = ^pl_q;

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Bench for rv_iopmp_check_arbiter: directed scenarios followed by random
// transactions, checked against a queue-free port-level reference model
// (pending bits, stored payloads, last served port).
module tb_rv_iopmp_check_arbiter;

    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int SW  = 2;
    localparam int NW  = 4;
    localparam int ACW = 2;
    localparam int TMO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N*AW-1:0]   req_addr_i = '0;
    logic [N*AW-1:0]   req_len_i = '0;
    logic [N*NW-1:0]   req_nbytes_i = '0;
    logic [N*SW-1:0]   req_sid_i = '0;
    logic [N*ACW-1:0]  req_access_i = '0;
    logic [N-1:0]      rsp_valid_o;
    logic [N-1:0]      rsp_allow_o;
    logic [N-1:0]      rsp_ready_i = '0;
    logic              chk_en_o;
    logic [AW-1:0]     chk_addr_o;
    logic [AW-1:0]     chk_len_o;
    logic [NW-1:0]     chk_nbytes_o;
    logic [SW-1:0]     chk_sid_o;
    logic [ACW-1:0]    chk_access_o;
    logic              chk_ready_i = 1'b0;
    logic              chk_valid_i = 1'b0;
    logic              chk_allow_i = 1'b0;
    logic              timeout_o;

    rv_iopmp_check_arbiter #(
        .NUM_PORTS      (N),
        .ADDR_WIDTH     (AW),
        .SID_WIDTH      (SW),
        .NBYTES_WIDTH   (NW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_len_i    (req_len_i),
        .req_nbytes_i (req_nbytes_i),
        .req_sid_i    (req_sid_i),
        .req_access_i (req_access_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_allow_o  (rsp_allow_o),
        .rsp_ready_i  (rsp_ready_i),
        .chk_en_o     (chk_en_o),
        .chk_addr_o   (chk_addr_o),
        .chk_len_o    (chk_len_o),
        .chk_nbytes_o (chk_nbytes_o),
        .chk_sid_o    (chk_sid_o),
        .chk_access_o (chk_access_o),
        .chk_ready_i  (chk_ready_i),
        .chk_valid_i  (chk_valid_i),
        .chk_allow_i  (chk_allow_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          pending [N];
    logic [63:0] m_addr  [N];
    logic [63:0] m_len   [N];
    logic [3:0]  m_nb    [N];
    logic [1:0]  m_sid   [N];
    logic [1:0]  m_acc   [N];
    int          last_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int exp_next();
        for (int i = 1; i <= N; i++) begin
            if (pending[(last_grant + i) % N]) return (last_grant + i) % N;
        end
        return -1;
    endfunction

    task automatic new_payload(input int p);
        m_addr[p] = {$urandom, $urandom};
        m_len[p]  = {$urandom, $urandom};
        m_nb[p]   = 4'($urandom);
        m_sid[p]  = 2'($urandom);
        m_acc[p]  = 2'($urandom);
    endtask

    task automatic drive_req();
        for (int p = 0; p < N; p++) begin
            req_valid_i[p]              = pending[p];
            req_addr_i[p*AW +: AW]      = m_addr[p];
            req_len_i[p*AW +: AW]       = m_len[p];
            req_nbytes_i[p*NW +: NW]    = m_nb[p];
            req_sid_i[p*SW +: SW]       = m_sid[p];
            req_access_i[p*ACW +: ACW]  = m_acc[p];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_rsp_allow"}, 64'(rsp_allow_o), 64'd0);
        check({tag, "_chk_en"},    64'(chk_en_o), 64'd0);
        check({tag, "_chk_addr"},  64'(chk_addr_o), 64'd0);
        check({tag, "_chk_len"},   64'(chk_len_o), 64'd0);
        check({tag, "_chk_nb"},    64'(chk_nbytes_o), 64'd0);
        check({tag, "_chk_sid"},   64'(chk_sid_o), 64'd0);
        check({tag, "_chk_acc"},   64'(chk_access_o), 64'd0);
        check({tag, "_timeout"},   64'(timeout_o), 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check_all_zero("reset");
        step();
        step();
        rst_i = 1'b0;
        last_grant = N - 1;
    endtask

    // One full transaction. force_port >= 0 overrides the model's expected port.
    task automatic do_txn(input int force_port, input int ready_dly, input int valid_dly,
                          input int rsp_dly, input bit allow, input bit keep, input bit tmo);
        int          p;
        int          n;
        bit          got;
        logic [N-1:0] oh;
        logic [63:0] ea, el;
        logic [3:0]  enb;
        logic [1:0]  esid, eacc;
        p = (force_port >= 0) ? force_port : exp_next();
        if (p < 0) begin
            check("no_expected_port", 64'd1, 64'd0);
            return;
        end
        oh = '0;
        oh[p] = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 12) begin
            step();
            n++;
            if (req_ready_o != '0) got = 1'b1;
        end
        check("grant_seen", 64'(got), 64'd1);
        if (!got) return;
        check("grant_port", 64'(req_ready_o), 64'(oh));
        check("issue_en", 64'(chk_en_o), 64'd1);
        check("issue_addr", 64'(chk_addr_o), m_addr[p]);
        check("issue_len", 64'(chk_len_o), m_len[p]);
        check("issue_nbytes", 64'(chk_nbytes_o), 64'(m_nb[p]));
        check("issue_sid", 64'(chk_sid_o), 64'(m_sid[p]));
        check("issue_access", 64'(chk_access_o), 64'(m_acc[p]));
        ea = m_addr[p]; el = m_len[p]; enb = m_nb[p]; esid = m_sid[p]; eacc = m_acc[p];
        // Requester moves on: payload changes after grant must not leak through.
        if (!keep) pending[p] = 1'b0;
        new_payload(p);
        drive_req();
        for (int i = 0; i < ready_dly; i++) begin
            step();
            check("issue_hold_en", 64'(chk_en_o), 64'd1);
            check("issue_hold_addr", 64'(chk_addr_o), ea);
            check("issue_hold_len", 64'(chk_len_o), el);
            check("issue_hold_nb", 64'(chk_nbytes_o), 64'(enb));
            check("issue_hold_sid", 64'(chk_sid_o), 64'(esid));
            check("issue_hold_acc", 64'(chk_access_o), 64'(eacc));
            check("issue_ready_pulse", 64'(req_ready_o), 64'd0);
        end
        chk_ready_i = 1'b1;
        step();
        chk_ready_i = 1'b0;
        check("wait_en_low", 64'(chk_en_o), 64'd0);
        if (tmo) begin
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
            for (int k = 1; k < TMO; k++) begin
                step();
                check("tmo_early", 64'(timeout_o), 64'd0);
                check("tmo_early_rsp", 64'(rsp_valid_o), 64'd0);
            end
            step();
            check("tmo_pulse", 64'(timeout_o), 64'd1);
            check("tmo_rsp_valid", 64'(rsp_valid_o), 64'(oh));
            check("tmo_rsp_deny", 64'(rsp_allow_o), 64'd0);
            allow = 1'b0;
`endif
        end else begin
            for (int i = 0; i < valid_dly; i++) begin
                step();
                check("wait_no_rsp", 64'(rsp_valid_o), 64'd0);
                check("wait_no_tmo", 64'(timeout_o), 64'd0);
            end
            chk_valid_i = 1'b1;
            chk_allow_i = allow;
            step();
            chk_valid_i = 1'b0;
            chk_allow_i = 1'b0;
            check("rsp_valid", 64'(rsp_valid_o), 64'(oh));
            check("rsp_allow", 64'(rsp_allow_o), allow ? 64'(oh) : 64'd0);
        end
        for (int i = 0; i < rsp_dly; i++) begin
            rsp_ready_i = N'($urandom) & ~oh;
            step();
            check("rsp_hold_valid", 64'(rsp_valid_o), 64'(oh));
            check("rsp_hold_allow", 64'(rsp_allow_o), allow ? 64'(oh) : 64'd0);
            check("rsp_hold_no_grant", 64'(req_ready_o), 64'd0);
            check("rsp_hold_no_tmo", 64'(timeout_o), 64'd0);
        end
        rsp_ready_i = oh;
        step();
        rsp_ready_i = '0;
        check("rsp_done_valid", 64'(rsp_valid_o), 64'd0);
        check("rsp_done_allow", 64'(rsp_allow_o), 64'd0);
        last_grant = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < N; p++) begin
            pending[p] = 1'b0;
            new_payload(p);
        end
        last_grant = N - 1;
        #2;
        do_reset();

        // Verdict pulse while idle is ignored.
        chk_valid_i = 1'b1;
        chk_allow_i = 1'b1;
        step();
        chk_valid_i = 1'b0;
        chk_allow_i = 1'b0;
        check("idle_pulse_rsp", 64'(rsp_valid_o), 64'd0);
        check("idle_pulse_en", 64'(chk_en_o), 64'd0);
        step();
        check("idle_pulse_rsp2", 64'(rsp_valid_o), 64'd0);
        check("idle_pulse_grant", 64'(req_ready_o), 64'd0);

        // Single port 2 request at minimum latency.
        pending[2] = 1'b1;
        m_addr[2]  = 64'h8000_0000;
        m_len[2]   = 64'h40;
        drive_req();
        do_txn(2, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // All ports valid continuously after reset: 0,1,2,3,0.
        do_reset();
        for (int p = 0; p < N; p++) pending[p] = 1'b1;
        drive_req();
        do_txn(0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        do_txn(1, 1, 0, 0, 1'b0, 1'b1, 1'b0);
        do_txn(2, 0, 2, 1, 1'b1, 1'b1, 1'b0);
        do_txn(3, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        do_txn(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Port 1 verdict held 10 cycles while port 3 waits.
        for (int p = 0; p < N; p++) pending[p] = 1'b0;
        pending[1] = 1'b1;
        pending[3] = 1'b1;
        drive_req();
        do_txn(1, 0, 0, 10, 1'b1, 1'b0, 1'b0);
        do_txn(3, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Reset while WAITing; late verdict must be dropped.
        pending[2] = 1'b1;
        drive_req();
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                step();
                if (req_ready_o != '0) got = 1'b1;
            end
            check("rst_wait_grant", 64'(req_ready_o), 64'h4);
            pending[2] = 1'b0;
            drive_req();
            chk_ready_i = 1'b1;
            step();
            chk_ready_i = 1'b0;
            step();
            check("rst_wait_pre_rsp", 64'(rsp_valid_o), 64'd0);
            rst_i = 1'b1;
            #1;
            check_all_zero("rst_mid");
            step();
            rst_i = 1'b0;
            last_grant = N - 1;
            chk_valid_i = 1'b1;
            chk_allow_i = 1'b1;
            step();
            chk_valid_i = 1'b0;
            chk_allow_i = 1'b0;
            check("rst_late_rsp", 64'(rsp_valid_o), 64'd0);
            check("rst_late_allow", 64'(rsp_allow_o), 64'd0);
            check("rst_late_en", 64'(chk_en_o), 64'd0);
        end
        pending[0] = 1'b1;
        pending[2] = 1'b1;
        drive_req();
        do_txn(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        do_txn(2, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Missing verdict: bounded with the timeout feature, unbounded without.
        pending[1] = 1'b1;
        drive_req();
`ifdef RV_IOPMP_CHECK_TIMEOUT_EN
        do_txn(1, 0, 0, 2, 1'b1, 1'b0, 1'b1);
`else
        do_txn(1, 0, 20, 1, 1'b1, 1'b0, 1'b0);
`endif

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            bit any;
            any = 1'b0;
            for (int p = 0; p < N; p++) begin
                if (!pending[p] && ($urandom_range(0, 1) == 1)) pending[p] = 1'b1;
                any |= pending[p];
            end
            if (!any) pending[$urandom_range(0, N - 1)] = 1'b1;
            drive_req();
            do_txn(-1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
